// File: rtl/ps2_key_if.sv
// Scan-code FIFO handshake between ps2_keyboard and its consumer.
//   kb_ready      : FIFO non-empty, kb_data valid
//   kb_data       : byte at the FIFO read pointer
//   kb_overflow   : FIFO overflow indication
//   kb_nextdata_n : low for one cycle pops the FIFO
// master = keyboard side, slave = consumer side.
interface ps2_key_if;
  logic       kb_ready;
  logic [7:0] kb_data;
  logic       kb_overflow;
  logic       kb_nextdata_n;

  modport master (
    output kb_ready,
    output kb_data,
    output kb_overflow,
    input  kb_nextdata_n
  );

  modport slave (
    input  kb_ready,
    input  kb_data,
    input  kb_overflow,
    output kb_nextdata_n
  );
endinterface

// File: rtl/ps2_key_ctrl.sv
// Sequencer between ps2_keyboard and the key display logic: drains the
// scan-code FIFO, parses set-2 E0/F0 prefixes, tracks the held key,
// suppresses typematic repeats and counts distinct presses.
// Ports:
//   clk, clrn    : clock, asynchronous active-low reset
//   kb           : FIFO handshake (slave side)
//   clr_err      : synchronous clear of err_ovf
//   key_code     : last pressed (make) scan code
//   key_ext      : key_code carried an E0 prefix
//   key_down     : key_code currently held
//   key_press    : 1-cycle strobe, new press accepted
//   key_release  : 1-cycle strobe, break code received
//   key_repeat   : 1-cycle strobe, typematic make of held key
//   press_count  : number of new presses, wraps
//   err_ovf      : sticky FIFO overflow flag
module ps2_key_ctrl #(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned TIMEOUT_CYC = 2000000
) (
  input  logic             clk,
  input  logic             clrn,
  ps2_key_if.slave         kb,
  input  logic             clr_err,
  output logic [7:0]       key_code,
  output logic             key_ext,
  output logic             key_down,
  output logic             key_press,
  output logic             key_release,
  output logic             key_repeat,
  output logic [CNT_W-1:0] press_count,
  output logic             err_ovf
);

  localparam int unsigned TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [7:0] BYTE_BRK = 8'hF0;
  localparam logic [7:0] BYTE_EXT = 8'hE0;

  typedef enum logic [1:0] {S_IDLE, S_POP, S_GAP} state_t;

  state_t           state_q, state_d;
  logic [7:0]       byte_q, byte_d;
  logic             brk_q, brk_d;
  logic             ext_q, ext_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             nextdata_n_q, nextdata_n_d;
  logic [7:0]       key_code_d;
  logic             key_ext_d, key_down_d;
  logic             key_press_d, key_release_d, key_repeat_d;
  logic [CNT_W-1:0] press_count_d;
  logic             err_ovf_d;
  logic             same_key;

  assign kb.kb_nextdata_n = nextdata_n_q;

  // State and output registers
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q      <= S_IDLE;
      byte_q       <= 8'h00;
      brk_q        <= 1'b0;
      ext_q        <= 1'b0;
      tmo_q        <= '0;
      nextdata_n_q <= 1'b1;
      key_code     <= 8'h00;
      key_ext      <= 1'b0;
      key_down     <= 1'b0;
      key_press    <= 1'b0;
      key_release  <= 1'b0;
      key_repeat   <= 1'b0;
      press_count  <= '0;
      err_ovf      <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_q       <= byte_d;
      brk_q        <= brk_d;
      ext_q        <= ext_d;
      tmo_q        <= tmo_d;
      nextdata_n_q <= nextdata_n_d;
      key_code     <= key_code_d;
      key_ext      <= key_ext_d;
      key_down     <= key_down_d;
      key_press    <= key_press_d;
      key_release  <= key_release_d;
      key_repeat   <= key_repeat_d;
      press_count  <= press_count_d;
      err_ovf      <= err_ovf_d;
    end
  end

  // Next-state, decode and prefix timeout
  always_comb begin
    state_d       = state_q;
    byte_d        = byte_q;
    brk_d         = brk_q;
    ext_d         = ext_q;
    tmo_d         = tmo_q;
    nextdata_n_d  = 1'b1;
    key_code_d    = key_code;
    key_ext_d     = key_ext;
    key_down_d    = key_down;
    key_press_d   = 1'b0;
    key_release_d = 1'b0;
    key_repeat_d  = 1'b0;
    press_count_d = press_count;
    err_ovf_d     = err_ovf;
    same_key      = (byte_q == key_code) && (ext_q == key_ext);

    // Overflow set has priority over clear
    if (kb.kb_overflow) begin
      err_ovf_d = 1'b1;
    end else if (clr_err) begin
      err_ovf_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (kb.kb_ready) begin
          byte_d       = kb.kb_data;
          tmo_d        = '0;
          nextdata_n_d = 1'b0;
          state_d      = S_POP;
        end else if (brk_q || ext_q) begin
          // A prefix left dangling too long is dropped
          if (tmo_q == TMO_LAST) begin
            brk_d = 1'b0;
            ext_d = 1'b0;
            tmo_d = '0;
          end else begin
            tmo_d = tmo_q + TMO_W'(1);
          end
        end
      end
      S_POP: begin
        state_d = S_GAP;
        if (byte_q == BYTE_BRK) begin
          brk_d = 1'b1;
        end else if (byte_q == BYTE_EXT) begin
          ext_d = 1'b1;
        end else begin
          if (brk_q) begin
            key_release_d = 1'b1;
            if (same_key) key_down_d = 1'b0;
          end else if (key_down && same_key) begin
            key_repeat_d = 1'b1;
          end else begin
            key_code_d    = byte_q;
            key_ext_d     = ext_q;
            key_down_d    = 1'b1;
            press_count_d = press_count + CNT_W'(1);
            key_press_d   = 1'b1;
          end
          brk_d = 1'b0;
          ext_d = 1'b0;
        end
      end
      S_GAP: begin
        // Lets ready/data settle after the read pointer moves
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Self-checking bench for ps2_key_ctrl: emulates the keyboard FIFO with a
// queue and compares every cycle against a key-event reference model.
module tb_ps2_key_ctrl;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned TMO   = 64;

  logic             clk = 1'b0;
  logic             clrn;
  logic             clr_err;
  logic [7:0]       key_code;
  logic             key_ext, key_down, key_press, key_release, key_repeat;
  logic [CNT_W-1:0] press_count;
  logic             err_ovf;

  ps2_key_if kb_if ();

  ps2_key_ctrl #(.CNT_W(CNT_W), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .clrn(clrn), .kb(kb_if), .clr_err(clr_err),
    .key_code(key_code), .key_ext(key_ext), .key_down(key_down),
    .key_press(key_press), .key_release(key_release), .key_repeat(key_repeat),
    .press_count(press_count), .err_ovf(err_ovf)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  logic [7:0] fifo[$];
  int         pop_cyc[$];

  // Reference model of key events
  logic [7:0]       m_code;
  logic             m_ext, m_down, m_brk, m_extp, m_err;
  logic [CNT_W-1:0] m_cnt;
  logic             e_press, e_rel, e_rep;
  int obs_press, obs_rel, obs_rep;
  bit rst_on_pop = 0;
  bit rst_hit    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_code = 8'h00; m_ext = 0; m_down = 0; m_brk = 0; m_extp = 0; m_err = 0;
    m_cnt = '0; e_press = 0; e_rel = 0; e_rep = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (b == 8'hF0) m_brk = 1;
    else if (b == 8'hE0) m_extp = 1;
    else begin
      if (m_brk) begin
        e_rel = 1;
        if (b == m_code && m_extp == m_ext) m_down = 0;
      end else if (m_down && b == m_code && m_extp == m_ext) begin
        e_rep = 1;
      end else begin
        m_code = b; m_ext = m_extp; m_down = 1; m_cnt = m_cnt + 1'b1; e_press = 1;
      end
      m_brk = 0; m_extp = 0;
    end
  endtask

  task automatic do_checks();
    check("key_code", 32'(key_code), 32'(m_code));
    check("key_ext", 32'(key_ext), 32'(m_ext));
    check("key_down", 32'(key_down), 32'(m_down));
    check("press_count", 32'(press_count), 32'(m_cnt));
    check("key_press", 32'(key_press), 32'(e_press));
    check("key_release", 32'(key_release), 32'(e_rel));
    check("key_repeat", 32'(key_repeat), 32'(e_rep));
    check("err_ovf", 32'(err_ovf), 32'(m_err));
  endtask

  task automatic drive_fifo();
    kb_if.kb_ready = (fifo.size() != 0);
    kb_if.kb_data  = (fifo.size() != 0) ? fifo[0] : 8'h00;
  endtask

  // One clock: check at negedge, apply FIFO pop and model at posedge
  task automatic step();
    bit pop_pend;
    @(negedge clk);
    do_checks();
    if (key_press === 1'b1) obs_press++;
    if (key_release === 1'b1) obs_rel++;
    if (key_repeat === 1'b1) obs_rep++;
    pop_pend = (kb_if.kb_nextdata_n === 1'b0);
    if (pop_pend) begin
      check("pop_while_empty", 32'(kb_if.kb_ready), 32'd1);
      pop_cyc.push_back(cyc);
    end
    if (rst_on_pop && pop_pend) begin
      clrn = 1'b0;
      #1;
      check("rst_nextdata_n", 32'(kb_if.kb_nextdata_n), 32'd1);
      model_reset();
      do_checks();
      pop_pend   = 0;
      rst_on_pop = 0;
      rst_hit    = 1;
    end
    @(posedge clk);
    if (clrn) begin
      if (kb_if.kb_overflow) m_err = 1;
      else if (clr_err) m_err = 0;
    end
    e_press = 0; e_rel = 0; e_rep = 0;
    if (pop_pend && fifo.size() != 0) model_byte(fifo.pop_front());
    #1;
    drive_fifo();
    cyc++;
  endtask

  task automatic push(input logic [7:0] b);
    fifo.push_back(b);
    drive_fifo();
  endtask

  task automatic drain();
    int n = 0;
    while (fifo.size() != 0 && n < 400) begin
      step();
      n++;
    end
    check("drain_bound", 32'(n < 400), 32'd1);
    repeat (3) step();
  endtask

  task automatic clr_obs();
    obs_press = 0; obs_rel = 0; obs_rep = 0;
  endtask

  initial begin
    logic [7:0] keys[4];
    logic [CNT_W-1:0] cnt0;
    int n;
    keys[0] = 8'h1C; keys[1] = 8'h1B; keys[2] = 8'h75; keys[3] = 8'h23;
    model_reset();
    clrn = 1'b0; clr_err = 1'b0;
    kb_if.kb_overflow = 1'b0;
    drive_fifo();
    repeat (2) @(posedge clk);
    #1;
    do_checks();
    check("reset_nextdata_n", 32'(kb_if.kb_nextdata_n), 32'd1);
    clrn = 1'b1;

    // 1: press / release of A
    clr_obs();
    push(8'h1C); push(8'hF0); push(8'h1C);
    drain();
    check("t1_press_count", 32'(press_count), 32'd1);
    check("t1_key_code", 32'(key_code), 32'h1C);
    check("t1_key_down", 32'(key_down), 32'd0);
    check("t1_presses", 32'(obs_press), 32'd1);
    check("t1_releases", 32'(obs_rel), 32'd1);

    // 2: typematic repeats suppressed
    clr_obs();
    push(8'h1C); push(8'h1C); push(8'h1C); push(8'hF0); push(8'h1C);
    drain();
    check("t2_presses", 32'(obs_press), 32'd1);
    check("t2_repeats", 32'(obs_rep), 32'd2);
    check("t2_press_count", 32'(press_count), 32'd2);
    check("t2_key_down", 32'(key_down), 32'd0);

    // 3: extended key, then plain key with same code
    push(8'hE0); push(8'h75); push(8'hE0); push(8'hF0); push(8'h75);
    drain();
    check("t3_key_code", 32'(key_code), 32'h75);
    check("t3_key_ext", 32'(key_ext), 32'd1);
    check("t3_press_count", 32'(press_count), 32'd3);
    check("t3_key_down", 32'(key_down), 32'd0);
    push(8'hE0); push(8'h75); push(8'h75);
    drain();
    check("t3b_press_count", 32'(press_count), 32'd5);
    check("t3b_key_ext", 32'(key_ext), 32'd0);

    // 4: pop spacing with four queued bytes
    pop_cyc.delete();
    push(8'h2B); push(8'hF0); push(8'h2B); push(8'h34);
    drain();
    check("t4_pop_count", 32'(pop_cyc.size()), 32'd4);
    if (pop_cyc.size() == 4)
      for (int i = 1; i < 4; i++)
        check("t4_pop_spacing", 32'(pop_cyc[i] - pop_cyc[i-1]), 32'd3);

    // Prefix timeout: short wait keeps F0, long wait drops it
    push(8'h1C); drain();
    clr_obs();
    push(8'hF0); drain();
    repeat (TMO / 2) step();
    push(8'h1C); drain();
    check("tmo_short_release", 32'(obs_rel), 32'd1);
    check("tmo_short_down", 32'(key_down), 32'd0);
    clr_obs();
    push(8'hF0); drain();
    repeat (TMO + 5) step();
    m_brk = 0; m_extp = 0;
    push(8'h1C); drain();
    check("tmo_long_press", 32'(obs_press), 32'd1);
    check("tmo_long_down", 32'(key_down), 32'd1);

    // Random key traffic
    for (int t = 0; t < 80; t++) begin
      logic [7:0] k;
      k = keys[$urandom_range(0, 3)];
      repeat ($urandom_range(0, 4)) step();
      case ($urandom_range(0, 3))
        0: push(k);
        1: begin push(8'hE0); push(k); end
        2: begin push(8'hF0); push(k); end
        default: begin push(8'hE0); push(8'hF0); push(k); end
      endcase
    end
    drain();

    // 5: press_count wrap with 256 press/release pairs
    cnt0 = m_cnt;
    for (int i = 0; i < 256; i++) begin
      push(8'h4D); push(8'hF0); push(8'h4D);
      drain();
    end
    check("t5_wrap", 32'(press_count), 32'(cnt0));

    // 6: overflow flag
    kb_if.kb_overflow = 1'b1; step(); kb_if.kb_overflow = 1'b0; step();
    check("ovf_set", 32'(err_ovf), 32'd1);
    clr_err = 1'b1; step(); clr_err = 1'b0; step();
    check("ovf_clr", 32'(err_ovf), 32'd0);
    kb_if.kb_overflow = 1'b1; clr_err = 1'b1; step();
    kb_if.kb_overflow = 1'b0; clr_err = 1'b0; step();
    check("ovf_set_wins", 32'(err_ovf), 32'd1);

    // 6: reset mid-POP
    rst_on_pop = 1;
    push(8'h1C);
    n = 0;
    while (!rst_hit && n < 20) begin
      step();
      n++;
    end
    check("rst_hit", 32'(rst_hit), 32'd1);
    rst_on_pop = 0;
    repeat (2) step();
    clrn = 1'b1;
    drain();
    check("rst_after_press_count", 32'(press_count), 32'd1);
    check("rst_after_key_code", 32'(key_code), 32'h1C);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
